// File: rtl/tag_array_pkg.sv
// Shared geometry, entry layout and line pack/unpack helpers for the
// 64-set x 4-way tag array controller.
package tag_array_pkg;
  localparam int SETS       = 64;
  localparam int WAYS       = 4;
  localparam int TAG_BITS   = 20;
  localparam int ENTRY_BITS = TAG_BITS + 1;
  localparam int SET_W      = $clog2(SETS);
  localparam int WAY_W      = $clog2(WAYS);
  localparam int LINE_W     = WAYS * ENTRY_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
  } tag_entry_t;

  // Index 0 sits in the low bits, so the packed line is way3..way0.
  typedef tag_entry_t [WAYS-1:0] tag_line_t;

  typedef enum logic {SWEEP, IDLE} state_e;

  function automatic tag_line_t unpack_line(input logic [LINE_W-1:0] d);
    return tag_line_t'(d);
  endfunction

  function automatic logic [LINE_W-1:0] pack_line(input tag_line_t l);
    return LINE_W'(l);
  endfunction

  function automatic tag_line_t rep_entry(input tag_entry_t e);
    tag_line_t l;
    for (int w = 0; w < WAYS; w++) l[w] = e;
    return l;
  endfunction
endpackage

// File: rtl/tag_victim_sel.sv
// Hit compare/encode over a returned tag line, plus miss victim choice:
// lowest invalid way, else a round-robin pointer that advances per such miss.
module tag_victim_sel
  import tag_array_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                resp_fire,
  input  logic [LINE_W-1:0]   rdata,
  input  logic [TAG_BITS-1:0] tag_q,
  output logic                hit,
  output logic [WAY_W-1:0]    way
);
  tag_line_t        line;
  logic [WAYS-1:0]  hit_vec, inv_vec;
  logic [WAY_W-1:0] hit_way, inv_way, rr_ptr;

  assign line = unpack_line(rdata);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = line[w].valid && (line[w].tag == tag_q);
    assign inv_vec[w] = ~line[w].valid;
  end

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (inv_vec[w]) inv_way = WAY_W'(w);
    end
  end

  assign hit = |hit_vec;
  assign way = hit ? hit_way : ((|inv_vec) ? inv_way : rr_ptr);

  always_ff @(posedge clock) begin
    if (reset) rr_ptr <= '0;
    else if (resp_fire && !hit && !(|inv_vec)) rr_ptr <= rr_ptr + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset && resp_fire) assert ($onehot0(hit_vec));
  end
endmodule

// File: rtl/tag_array_ctrl.sv
// Owns the tag SRAM RW port: reset/flush sweep, fills/invalidates and
// one-cycle-latency lookups with hit/victim response.
module tag_array_ctrl
  import tag_array_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_W-1:0]    req_set,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAY_W-1:0]    resp_way,
  input  logic                fill_valid,
  output logic                fill_ready,
  input  logic [SET_W-1:0]    fill_set,
  input  logic [WAY_W-1:0]    fill_way,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic                fill_inval,
  input  logic                flush_req,
  output logic                busy,
  output logic [SET_W-1:0]    sram_addr,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [LINE_W-1:0]   sram_wdata,
  output logic [WAYS-1:0]     sram_wmask,
  input  logic [LINE_W-1:0]   sram_rdata
);
  localparam int STAGES = 1;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    sweep_cnt;
  logic [TAG_BITS-1:0] tag_q;
  logic                req_fire, vld_q, vic_hit;
  logic [WAY_W-1:0]    vic_way;
  logic [STAGES:0]     vld_pipe;
  tag_entry_t          fill_entry;

  assign fill_entry = '{valid: ~fill_inval, tag: fill_tag};
  assign vld_pipe   = {vld_q, req_fire};

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    fill_ready = 1'b0;
    busy       = 1'b0;
    req_fire   = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (reset) begin
      busy = 1'b1;
    end else begin
      case (state_q)
        SWEEP: begin
          busy       = 1'b1;
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = sweep_cnt;
          sram_wmask = '1;
          if (sweep_cnt == SET_W'(SETS-1)) state_d = IDLE;
        end
        IDLE: begin
          fill_ready = ~flush_req;
          req_ready  = ~flush_req & ~fill_valid;
          // Flush cycle itself leaves the SRAM port idle.
          if (flush_req) begin
            state_d = SWEEP;
          end else if (fill_valid) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = fill_set;
            sram_wmask = WAYS'(1) << fill_way;
            sram_wdata = pack_line(rep_entry(fill_entry));
          end else if (req_valid) begin
            req_fire  = 1'b1;
            sram_en   = 1'b1;
            sram_addr = req_set;
          end
        end
        default: state_d = SWEEP;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SWEEP;
      sweep_cnt <= '0;
      vld_q     <= 1'b0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      sweep_cnt <= (state_q == SWEEP) ? sweep_cnt + 1'b1 : '0;
      vld_q     <= vld_pipe[0];
      if (req_fire) tag_q <= req_tag;
    end
  end

  // A response in flight when flush arrives is still delivered from vld_q.
  assign resp_valid = vld_pipe[STAGES] & ~reset;
  assign resp_hit   = resp_valid & vic_hit;
  assign resp_way   = resp_valid ? vic_way : '0;

  tag_victim_sel u_vic (
    .clock     (clock),
    .reset     (reset),
    .resp_fire (resp_valid),
    .rdata     (sram_rdata),
    .tag_q     (tag_q),
    .hit       (vic_hit),
    .way       (vic_way)
  );
endmodule

// File: tb/tb_tag_array_ctrl.sv
// Directed bench for tag_array_ctrl with a behavioural single-port tag SRAM.
module tb_tag_array_ctrl;
  import tag_array_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0, req_ready;
  logic [SET_W-1:0]    req_set = '0;
  logic [TAG_BITS-1:0] req_tag = '0;
  logic                resp_valid, resp_hit;
  logic [WAY_W-1:0]    resp_way;
  logic                fill_valid = 1'b0, fill_ready;
  logic [SET_W-1:0]    fill_set = '0;
  logic [WAY_W-1:0]    fill_way = '0;
  logic [TAG_BITS-1:0] fill_tag = '0;
  logic                fill_inval = 1'b0;
  logic                flush_req = 1'b0;
  logic                busy;
  logic [SET_W-1:0]    sram_addr;
  logic                sram_en, sram_wmode;
  logic [LINE_W-1:0]   sram_wdata;
  logic [WAYS-1:0]     sram_wmask;
  logic [LINE_W-1:0]   sram_rdata = '0;
  logic [LINE_W-1:0]   mem [SETS];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  tag_array_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_set(fill_set),
    .fill_way(fill_way), .fill_tag(fill_tag), .fill_inval(fill_inval),
    .flush_req(flush_req), .busy(busy),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int w = 0; w < WAYS; w++)
          if (sram_wmask[w]) mem[sram_addr][w*ENTRY_BITS +: ENTRY_BITS] <= sram_wdata[w*ENTRY_BITS +: ENTRY_BITS];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  function automatic logic [LINE_W-1:0] rep(input logic v, input logic [TAG_BITS-1:0] t);
    return {v, t, v, t, v, t, v, t};
  endfunction

  task automatic drive_idle();
    req_valid = 0; fill_valid = 0; fill_inval = 0; flush_req = 0;
  endtask

  task automatic do_fill(input int s, input int w, input logic [TAG_BITS-1:0] t, input logic inv);
    fill_valid = 1; fill_set = SET_W'(s); fill_way = WAY_W'(w); fill_tag = t; fill_inval = inv;
    req_valid = 0;
    settle();
    chk("fill_ready", LINE_W'(fill_ready), 1);
    tick();
    drive_idle();
  endtask

  // Checks n consecutive sweep cycles starting at sweep_cnt 0.
  task automatic sweep_run(input int n, input int flush_at);
    for (int i = 0; i < n; i++) begin
      flush_req = (i == flush_at);
      settle();
      chk("sweep_busy", LINE_W'(busy), 1);
      chk("sweep_en", LINE_W'({sram_en, sram_wmode}), 3);
      chk("sweep_addr", LINE_W'(sram_addr), LINE_W'(i));
      chk("sweep_mask", LINE_W'(sram_wmask), 4'hF);
      chk("sweep_rdy", LINE_W'({req_ready, fill_ready}), 0);
      tick();
    end
    flush_req = 0;
  endtask

  task automatic lookup_accept(input int s, input logic [TAG_BITS-1:0] t);
    req_valid = 1; req_set = SET_W'(s); req_tag = t;
    settle();
    chk("req_ready", LINE_W'(req_ready), 1);
    chk("lookup_rd", LINE_W'({sram_en, sram_wmode, sram_addr}), LINE_W'({1'b1, 1'b0, SET_W'(s)}));
  endtask

  task automatic resp_chk(input string name, input logic hit, input int way);
    settle();
    chk(name, LINE_W'({resp_valid, resp_hit, resp_way}), LINE_W'({1'b1, hit, WAY_W'(way)}));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    settle();
    chk("rst_busy", LINE_W'(busy), 1);
    chk("rst_outs", LINE_W'({sram_en, sram_wmode, sram_addr, sram_wmask, req_ready, fill_ready, resp_valid}), 0);
    chk("rst_wdata", sram_wdata, 0);
    tick();
    reset = 0;
    sweep_run(64, -1);
    settle();
    chk("idle_busy", LINE_W'(busy), 0);
    chk("idle_rdy", LINE_W'({req_ready, fill_ready}), 2'b11);

    // Fill + hit
    fill_valid = 1; fill_set = 5; fill_way = 2; fill_tag = 20'hABCDE;
    settle();
    chk("fill_port", LINE_W'({sram_en, sram_wmode, sram_addr, sram_wmask}), LINE_W'({2'b11, 6'd5, 4'b0100}));
    chk("fill_wdata", sram_wdata, rep(1'b1, 20'hABCDE));
    tick(); drive_idle();
    lookup_accept(5, 20'hABCDE);
    tick(); req_valid = 0;
    resp_chk("hit_s5", 1'b1, 2);
    tick();
    settle();
    chk("resp_drop", LINE_W'(resp_valid), 0);

    // Full set: round-robin victims
    do_fill(9, 0, 20'h11111, 0);
    do_fill(9, 1, 20'h22222, 0);
    do_fill(9, 2, 20'h33333, 0);
    do_fill(9, 3, 20'h44444, 0);
    lookup_accept(9, 20'h55555);
    tick(); lookup_accept(9, 20'h55555); resp_chk("rr0", 1'b0, 0);
    tick(); lookup_accept(9, 20'h55555); resp_chk("rr1", 1'b0, 1);
    tick(); req_valid = 0;              resp_chk("rr2", 1'b0, 2);
    tick();

    // Invalid ways take priority and leave rr_ptr alone
    fill_valid = 1; fill_set = 9; fill_way = 2; fill_tag = 20'h33333; fill_inval = 1;
    settle();
    chk("inval_wdata", sram_wdata, rep(1'b0, 20'h33333));
    tick(); drive_idle();
    do_fill(9, 3, 20'h44444, 1);
    lookup_accept(9, 20'h55555);
    tick(); req_valid = 0; resp_chk("inv_vic", 1'b0, 2);
    tick();
    do_fill(9, 2, 20'h33333, 0);
    do_fill(9, 3, 20'h44444, 0);
    lookup_accept(9, 20'h55555);
    tick(); req_valid = 0; resp_chk("rr3_kept", 1'b0, 3);
    tick();

    // Fill beats lookup in the same cycle
    fill_valid = 1; fill_set = 7; fill_way = 1; fill_tag = 20'h77777;
    req_valid = 1; req_set = 7; req_tag = 20'h77777;
    settle();
    chk("prio_rdy", LINE_W'({req_ready, fill_ready}), 2'b01);
    chk("prio_port", LINE_W'({sram_wmode, sram_addr, sram_wmask}), LINE_W'({1'b1, 6'd7, 4'b0010}));
    tick(); fill_valid = 0;
    lookup_accept(7, 20'h77777);
    tick(); req_valid = 0; resp_chk("prio_hit", 1'b1, 1);
    tick();

    // Flush with a response in flight
    do_fill(3, 0, 20'h33333, 0);
    lookup_accept(3, 20'h33333);
    tick(); req_valid = 0; flush_req = 1;
    resp_chk("flush_resp", 1'b1, 0);
    chk("flush_port", LINE_W'({sram_en, req_ready, fill_ready}), 0);
    tick(); flush_req = 0;
    sweep_run(64, 10);
    settle();
    chk("post_flush_busy", LINE_W'(busy), 0);
    lookup_accept(3, 20'h33333);
    tick(); req_valid = 0; resp_chk("flush_miss", 1'b0, 0);
    tick();

    // Reset mid-sweep restarts the count
    flush_req = 1; tick(); flush_req = 0;
    sweep_run(30, -1);
    settle();
    chk("pre_rst_addr", LINE_W'(sram_addr), 30);
    reset = 1;
    settle();
    chk("mid_rst", LINE_W'({busy, sram_en, sram_wmode}), 3'b100);
    tick(); reset = 0;
    sweep_run(64, -1);
    settle();
    chk("rst_sweep_done", LINE_W'({busy, req_ready}), 2'b01);

    // Reset mid-lookup drops the response
    lookup_accept(5, 20'hABCDE);
    tick(); req_valid = 0; reset = 1;
    settle();
    chk("rst_drop_resp", LINE_W'({resp_valid, resp_hit, resp_way}), 0);
    tick(); reset = 0;
    settle();
    chk("rst_no_resp", LINE_W'(resp_valid), 0);
    sweep_run(64, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
